// File: rtl/pc_fetch_unit.sv
// Program-counter, fetch and control-transfer unit: owns PC/IR and the instruction bus,
// resolves branches locally and hands everything else to the execute controller.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       instruction,
    input  logic              flag_n,
    input  logic              flag_v,
    input  logic              flag_z,
    output logic              issue_valid,
    input  logic              exec_done,
    input  logic [1:0]        exec_mem_cmd,
    input  logic [ADDR_W-1:0] exec_mem_addr,
    input  logic [ADDR_W-1:0] exec_target,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_pc,
    output logic              halt,
    output logic [CNT_W-1:0]  retired
);

    // state | meaning
    // RST   | one cycle after reset, bus idle
    // IF    | read mem[PC], hold until mem_ready
    // DEC   | decode IR, resolve branches/BL, PC already incremented
    // EXEC  | execute controller owns the bus until exec_done
    // HALT  | stopped, only reset leaves
    typedef enum logic [2:0] {
        ST_RST,
        ST_IF,
        ST_DEC,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_READ = 2'b01;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_BCC  = 3'b001;
    localparam logic [2:0] OPC_BR   = 3'b010;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_BX  = 2'b00;
    localparam logic [1:0] OP_BLX = 2'b10;
    localparam logic [1:0] OP_BL  = 2'b11;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [15:0]         ir, ir_n;
    logic                retire;

    logic [2:0]          opcode;
    logic [1:0]          op;
    logic [2:0]          cond;
    logic [ADDR_W-1:0]   imm;
    logic [ADDR_W-1:0]   target;
    logic                taken;

    assign opcode      = ir[15:13];
    assign op          = ir[12:11];
    assign cond        = ir[10:8];
    assign instruction = ir;

    // Narrow address spaces simply keep the low bits; the modular sum is identical.
    if (ADDR_W > 8) begin : g_sext
        assign imm = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
    end else begin : g_trunc
        assign imm = ir[ADDR_W-1:0];
    end

    assign target = pc + imm;

    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = flag_z;
            3'b010:  taken = !flag_z;
            3'b011:  taken = flag_n ^ flag_v;
            3'b100:  taken = (flag_n ^ flag_v) | flag_z;
            3'b101:  taken = !(flag_n ^ flag_v);
            3'b110:  taken = !(flag_n ^ flag_v) & !flag_z;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            if (retire && (retired != {CNT_W{1'b1}})) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        retire      = 1'b0;
        mem_cmd     = MEM_NONE;
        mem_addr    = pc;
        issue_valid = 1'b0;
        link_we     = 1'b0;
        link_pc     = '0;
        halt        = 1'b0;

        case (state)
            ST_RST: begin
                state_n = ST_IF;
            end

            ST_IF: begin
                mem_cmd = MEM_READ;
                if (mem_ready) begin
                    ir_n    = in;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = ST_DEC;
                end
            end

            ST_DEC: begin
                state_n = ST_IF;
                case (opcode)
                    OPC_NOP: begin
                        retire = 1'b1;
                    end
                    OPC_BCC: begin
                        retire = 1'b1;
                        if (taken) begin
                            pc_n = target;
                        end
                    end
                    OPC_BR: begin
                        case (op)
                            OP_BL: begin
                                link_we = 1'b1;
                                link_pc = pc;
                                pc_n    = target;
                                retire  = 1'b1;
                            end
                            OP_BX, OP_BLX: begin
                                state_n = ST_EXEC;
                            end
                            default: begin
                                retire = 1'b1;
                            end
                        endcase
                    end
                    OPC_HALT: begin
                        retire  = 1'b1;
                        state_n = ST_HALT;
                    end
                    default: begin
                        state_n = ST_EXEC;
                    end
                endcase
            end

            ST_EXEC: begin
                issue_valid = 1'b1;
                mem_cmd     = exec_mem_cmd;
                mem_addr    = exec_mem_addr;
                if (exec_done) begin
                    retire  = 1'b1;
                    state_n = ST_IF;
                    if (opcode == OPC_BR) begin
                        pc_n = exec_target;
                        // Link written on the done cycle so the controller reads R7 first.
                        if (op == OP_BLX) begin
                            link_we = 1'b1;
                            link_pc = pc;
                        end
                    end
                end
            end

            ST_HALT: begin
                halt = 1'b1;
            end

            default: begin
                state_n = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: default-width unit plus a 4-bit-address,
// 2-bit-counter unit for wrap and saturation.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        mem_ready;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] instruction;
    logic        flag_n, flag_v, flag_z;
    logic        issue_valid;
    logic        exec_done;
    logic [1:0]  exec_mem_cmd;
    logic [8:0]  exec_mem_addr;
    logic [8:0]  exec_target;
    logic        link_we;
    logic [8:0]  link_pc;
    logic        halt;
    logic [15:0] retired;

    logic        s_reset;
    logic [15:0] s_in;
    logic        s_ready;
    logic [1:0]  s_cmd;
    logic [3:0]  s_addr;
    logic [15:0] s_instr;
    logic        s_zero;
    logic        s_issue;
    logic [1:0]  s_exec_cmd;
    logic [3:0]  s_exec_addr;
    logic [3:0]  s_exec_target;
    logic        s_link_we;
    logic [3:0]  s_link_pc;
    logic        s_halt;
    logic [1:0]  s_retired;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.ADDR_W(9), .RESET_PC(9'd0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in(in), .mem_ready(mem_ready),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .instruction(instruction),
        .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z),
        .issue_valid(issue_valid), .exec_done(exec_done),
        .exec_mem_cmd(exec_mem_cmd), .exec_mem_addr(exec_mem_addr),
        .exec_target(exec_target), .link_we(link_we), .link_pc(link_pc),
        .halt(halt), .retired(retired)
    );

    pc_fetch_unit #(.ADDR_W(4), .RESET_PC(4'hF), .CNT_W(2)) dut_small (
        .clk(clk), .reset(s_reset), .in(s_in), .mem_ready(s_ready),
        .mem_cmd(s_cmd), .mem_addr(s_addr), .instruction(s_instr),
        .flag_n(s_zero), .flag_v(s_zero), .flag_z(s_zero),
        .issue_valid(s_issue), .exec_done(s_zero),
        .exec_mem_cmd(s_exec_cmd), .exec_mem_addr(s_exec_addr),
        .exec_target(s_exec_target), .link_we(s_link_we), .link_pc(s_link_pc),
        .halt(s_halt), .retired(s_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the unit in RST with reset already released.
    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Reset, then run NOPs until the unit is in IF with PC = n.
    task automatic run_to_if(input int n);
        do_reset();
        in = 16'h0000;
        mem_ready = 1'b1;
        exec_done = 1'b0;
        repeat (2 * n + 1) cyc();
    endtask

    initial begin
        reset = 1'b1; s_reset = 1'b1;
        in = 16'h0000; mem_ready = 1'b1;
        flag_n = 1'b0; flag_v = 1'b0; flag_z = 1'b0;
        exec_done = 1'b0; exec_mem_cmd = 2'b00; exec_mem_addr = '0; exec_target = '0;
        s_in = 16'h0000; s_ready = 1'b1; s_zero = 1'b0;
        s_exec_cmd = 2'b00; s_exec_addr = '0; s_exec_target = '0;
        cyc(); cyc();

        chk("rst_mem_cmd", mem_cmd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ir", instruction, 0);
        chk("rst_outs", {issue_valid, link_we, halt}, 0);
        chk("rst_link_pc", link_pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_small_addr", s_addr, 4'hF);

        // NOP stream: address sequence 0,0,1,1,2 and small-unit wrap 15 -> 0
        reset = 1'b0; s_reset = 1'b0;
        #1;
        chk("nop_addr_e0", mem_addr, 0);
        cyc();
        chk("nop_addr_e1", mem_addr, 0);
        chk("nop_cmd_e1", mem_cmd, 1);
        chk("small_if_addr", s_addr, 4'hF);
        chk("small_if_cmd", s_cmd, 1);
        cyc();
        chk("nop_addr_e2", mem_addr, 1);
        chk("nop_cmd_e2", mem_cmd, 0);
        chk("small_wrap_addr", s_addr, 4'h0);
        cyc();
        chk("nop_addr_e3", mem_addr, 1);
        cyc();
        chk("nop_addr_e4", mem_addr, 2);
        repeat (3) cyc();
        chk("nop_retired3", retired, 3);
        chk("nop_addr_e7", mem_addr, 3);
        repeat (10) cyc();
        chk("nop_retired8", retired, 8);
        chk("small_retired_sat", s_retired, 3);

        // Wait states at PC=0
        do_reset();
        chk("reset_clears_retired", retired, 0);
        in = 16'h1234; mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("wait_cmd", mem_cmd, 1);
            chk("wait_addr", mem_addr, 0);
            chk("wait_ir", instruction, 0);
            if (i < 2) cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("wait_release_cmd", mem_cmd, 1);
        cyc();
        chk("wait_ir_loaded", instruction, 16'h1234);
        chk("wait_pc_inc", mem_addr, 1);
        in = 16'h0000;
        cyc();
        chk("wait_nop_retired", retired, 1);

        // BLT taken (N=1,V=0) at PC=4 -> 10
        run_to_if(4);
        flag_n = 1'b1; flag_v = 1'b0; flag_z = 1'b0;
        in = 16'h2305;
        cyc();
        chk("blt_dec_addr", mem_addr, 5);
        chk("blt_dec_cmd", mem_cmd, 0);
        in = 16'h0000;
        cyc();
        chk("blt_target", mem_addr, 10);

        // BGE not taken with N!=V
        run_to_if(4);
        in = 16'h2505;
        cyc(); in = 16'h0000; cyc();
        chk("bge_not_taken", mem_addr, 5);

        // BGT with Z=1 not taken, then with Z=0 taken
        run_to_if(4);
        flag_n = 1'b0; flag_v = 1'b0; flag_z = 1'b1;
        in = 16'h2605;
        cyc(); in = 16'h0000; cyc();
        chk("bgt_z_not_taken", mem_addr, 5);
        run_to_if(4);
        flag_z = 1'b0;
        in = 16'h2605;
        cyc(); in = 16'h0000; cyc();
        chk("bgt_taken", mem_addr, 10);

        // BEQ taken with Z=1
        run_to_if(4);
        flag_z = 1'b1;
        in = 16'h2105;
        cyc(); in = 16'h0000; cyc();
        chk("beq_taken", mem_addr, 10);
        flag_z = 1'b0;

        // B imm=-1 at PC=0 loops to 0
        run_to_if(0);
        in = 16'h20FF;
        cyc();
        chk("b_dec_addr", mem_addr, 1);
        in = 16'h0000;
        cyc();
        chk("b_back_target", mem_addr, 0);

        // BL at PC=2: link 3, target 3+3=6
        run_to_if(2);
        in = 16'h5F03;
        cyc();
        chk("bl_link_we", link_we, 1);
        chk("bl_link_pc", link_pc, 3);
        chk("bl_retired_before", retired, 2);
        in = 16'h0000;
        cyc();
        chk("bl_target", mem_addr, 6);
        chk("bl_link_we_off", link_we, 0);
        chk("bl_retired_after", retired, 3);

        // BLX at PC=5, done on second EXEC cycle, target 0x40
        run_to_if(5);
        in = 16'h5000;
        cyc();
        exec_done = 1'b1;
        #1;
        chk("blx_dec_issue", issue_valid, 0);
        chk("blx_dec_link", link_we, 0);
        cyc();
        exec_done = 1'b0; exec_mem_cmd = 2'b10; exec_mem_addr = 9'h055;
        #1;
        chk("blx_exec1_issue", issue_valid, 1);
        chk("blx_exec1_bus", {mem_cmd, mem_addr}, {2'b10, 9'h055});
        chk("blx_exec1_link", link_we, 0);
        cyc();
        exec_done = 1'b1; exec_target = 9'h040;
        #1;
        chk("blx_done_link_we", link_we, 1);
        chk("blx_done_link_pc", link_pc, 6);
        cyc();
        exec_done = 1'b0; exec_mem_cmd = 2'b00;
        #1;
        chk("blx_target", mem_addr, 9'h040);
        chk("blx_fetch_cmd", mem_cmd, 1);
        chk("blx_link_off", link_we, 0);
        chk("blx_retired", retired, 6);

        // ALU op 0xA000: bus follows execute controller
        run_to_if(1);
        in = 16'hA000;
        cyc(); cyc();
        exec_mem_cmd = 2'b01; exec_mem_addr = 9'h012;
        #1;
        chk("alu_issue", issue_valid, 1);
        chk("alu_bus1", {mem_cmd, mem_addr}, {2'b01, 9'h012});
        cyc();
        exec_mem_cmd = 2'b10; exec_mem_addr = 9'h1AB; exec_done = 1'b1;
        #1;
        chk("alu_bus2", {mem_cmd, mem_addr}, {2'b10, 9'h1AB});
        cyc();
        exec_done = 1'b0; exec_mem_cmd = 2'b00; in = 16'h6000;
        #1;
        chk("alu_pc_kept", mem_addr, 2);
        chk("alu_issue_off", issue_valid, 0);
        chk("alu_retired", retired, 2);
        cyc(); cyc();
        exec_mem_cmd = 2'b11; exec_mem_addr = 9'h0F0;
        #1;
        chk("ld_issue", issue_valid, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0; exec_mem_cmd = 2'b00;
        #1;
        chk("midexec_rst_issue", issue_valid, 0);
        chk("midexec_rst_bus", {mem_cmd, mem_addr}, 0);
        chk("midexec_rst_ir", instruction, 0);
        cyc();
        chk("midexec_rst_refetch", {mem_cmd, mem_addr}, {2'b01, 9'h000});

        // HALT at PC=3
        run_to_if(3);
        in = 16'hE000;
        cyc(); cyc();
        in = 16'h0000;
        chk("halt_retired", retired, 4);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {halt, mem_cmd}, 3'b100);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("halt_cleared", halt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
